// File: rtl/serial_regfile_pkg.sv
// Shared types for the serial register file: datapath width, ALU opcodes and controller states.
package serial_regfile_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_OR    = 3'd2,
        OP_AND   = 3'd3,
        OP_XOR   = 3'd4,
        OP_PASSB = 3'd5,
        OP_PASSA = 3'd6,
        OP_ZERO  = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_shifter.sv
// Parallel-load shift register: bit 0 is the serial output, serial input enters at the MSB.
module serial_shifter
    import serial_regfile_pkg::*;
(
    input  logic              clk,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              shift,
    input  logic              sin,
    output logic [DATA_W-1:0] q
);

    // Pure datapath: contents are meaningless until loaded, so no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= {sin, q[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/serial_regfile.sv
// Small register file that streams two operands LSB-first through an external bit-serial ALU
// and writes the 8-bit serial result back, with a parallel host port for load and inspection.
module serial_regfile
    import serial_regfile_pkg::*;
#(
    parameter int NREGS = 4,
    parameter int RA_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [RA_W-1:0]   rs1,
    input  logic [RA_W-1:0]   rs2,
    input  logic [RA_W-1:0]   rd,
    input  logic              we,
    output logic              busy,
    output logic              done,
    output logic [2:0]        alu_op,
    output logic              alu_run,
    output logic              a_out,
    output logic              b_out,
    input  logic              y_in,
    input  logic              c_in,
    output logic              flag,
    input  logic              host_we,
    input  logic [RA_W-1:0]   host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic [RA_W-1:0]   host_raddr,
    output logic [DATA_W-1:0] host_rdata
);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q;
    alu_op_e           op_q;
    logic [RA_W-1:0]   rd_q;
    logic              we_q;
    logic              flag_q;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] a_q, b_q, res_q;
    logic              launch, shifting, in_done;
    logic              shift_unused;

    assign launch   = (state_q == S_IDLE) && start;
    assign shifting = (state_q == S_SHIFT);
    assign in_done  = (state_q == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SHIFT;
            S_SHIFT: if (cnt_q == 3'd7) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = shifting || in_done;
        done    = in_done;
        alu_run = shifting || in_done;
        a_out   = shifting && a_q[0];
        b_out   = shifting && b_q[0];
        alu_op  = op_q;
        flag    = flag_q;
    end

    // The bit counter only runs in SHIFT, so its natural 7->0 rollover coincides with SHIFT exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 3'd0;
            op_q   <= OP_ADD;
            we_q   <= 1'b0;
            flag_q <= 1'b0;
        end else begin
            if (launch) begin
                op_q  <= alu_op_e'(op);
                rd_q  <= rd;
                we_q  <= we;
                cnt_q <= 3'd0;
            end else if (shifting) begin
                cnt_q <= cnt_q + 3'd1;
            end
            if (in_done) begin
                flag_q <= c_in;
            end
        end
    end

    // Writeback is assigned after the host write so it wins a same-register collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (host_we) begin
                regs_q[host_addr] <= host_wdata;
            end
            if (in_done && we_q) begin
                regs_q[rd_q] <= res_q;
            end
        end
    end

    assign host_rdata = regs_q[host_raddr];

    serial_shifter u_shift_a (
        .clk       (clk),
        .load      (launch),
        .load_data (regs_q[rs1]),
        .shift     (shifting),
        .sin       (1'b0),
        .q         (a_q)
    );

    serial_shifter u_shift_b (
        .clk       (clk),
        .load      (launch),
        .load_data (regs_q[rs2]),
        .shift     (shifting),
        .sin       (1'b0),
        .q         (b_q)
    );

    serial_shifter u_shift_res (
        .clk       (clk),
        .load      (launch),
        .load_data ('0),
        .shift     (shifting),
        .sin       (y_in),
        .q         (res_q)
    );

    // Only bit 0 of each operand shifter is ever observed.
    assign shift_unused = ^{a_q[DATA_W-1:1], b_q[DATA_W-1:1]};

endmodule

// File: tb/tb_serial_regfile.sv
// Bench for serial_regfile: attaches a bit-serial ALU and checks results against an arithmetic reference model.
module tb_serial_regfile;

    logic       clk = 1'b0;
    logic       rst, start, we, host_we;
    logic [2:0] op;
    logic [1:0] rs1, rs2, rd, host_addr, host_raddr;
    logic [7:0] host_wdata, host_rdata;
    logic       busy, done, alu_run, a_out, b_out, y_in, c_in, flag;
    logic [2:0] alu_op;

    int checks = 0;
    int failures = 0;

    logic [7:0] mreg [4];
    logic       mflag;

    serial_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .we         (we),
        .busy       (busy),
        .done       (done),
        .alu_op     (alu_op),
        .alu_run    (alu_run),
        .a_out      (a_out),
        .b_out      (b_out),
        .y_in       (y_in),
        .c_in       (c_in),
        .flag       (flag),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_raddr (host_raddr),
        .host_rdata (host_rdata)
    );

    always #5 clk = ~clk;

    // Attached bit-serial ALU: carry/borrow register held cleared while alu_run is low.
    logic alu_c;
    always_comb begin
        y_in = 1'b0;
        case (alu_op)
            3'd0, 3'd1: y_in = a_out ^ b_out ^ alu_c;
            3'd2:       y_in = a_out | b_out;
            3'd3:       y_in = a_out & b_out;
            3'd4:       y_in = a_out ^ b_out;
            3'd5:       y_in = b_out;
            3'd6:       y_in = a_out;
            default:    y_in = 1'b0;
        endcase
    end
    assign c_in = alu_c;

    always_ff @(posedge clk) begin
        if (!alu_run) begin
            alu_c <= 1'b0;
        end else if (alu_op == 3'd0) begin
            alu_c <= (a_out & b_out) | (alu_c & (a_out ^ b_out));
        end else if (alu_op == 3'd1) begin
            alu_c <= (~a_out & b_out) | (~(a_out ^ b_out) & alu_c);
        end else begin
            alu_c <= 1'b0;
        end
    end

    function automatic logic [8:0] ref_alu(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] d;
        d = a - b;
        case (o)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {(a < b), d};
            3'd2:    return {1'b0, a | b};
            3'd3:    return {1'b0, a & b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {1'b0, b};
            3'd6:    return {1'b0, a};
            default: return 9'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            host_raddr = 2'(i);
            #1;
            checks++;
            if (host_rdata !== mreg[i]) begin
                failures++;
                $display("FAIL %s r%0d: got %02h expected %02h", tag, i, host_rdata, mreg[i]);
            end
        end
        checks++;
        if (flag !== mflag) begin
            failures++;
            $display("FAIL %s flag: got %b expected %b", tag, flag, mflag);
        end
    endtask

    task automatic host_write(input logic [1:0] addr, input logic [7:0] data);
        host_we = 1'b1;
        host_addr = addr;
        host_wdata = data;
        tick();
        mreg[addr] = data;
        host_we = 1'b0;
    endtask

    // hw_cycle 0..7 = host write during that SHIFT cycle, 8 = during DONE, otherwise none.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [1:0] s1, input logic [1:0] s2,
                         input logic [1:0] d, input logic w, input logic hold_start,
                         input int hw_cycle, input logic [1:0] hw_addr, input logic [7:0] hw_data);
        logic [7:0] sa, sb;
        logic [8:0] exp;
        sa = mreg[s1];
        sb = mreg[s2];
        exp = ref_alu(o, sa, sb);
        op = o; rs1 = s1; rs2 = s2; rd = d; we = w; start = 1'b1;
        tick();
        start = hold_start;
        for (int i = 0; i <= 8; i++) begin
            if (i == hw_cycle) begin
                host_we = 1'b1; host_addr = hw_addr; host_wdata = hw_data;
                mreg[hw_addr] = hw_data;
            end else begin
                host_we = 1'b0;
            end
            checks++;
            if (i < 8) begin
                if ({a_out, b_out, busy, done, alu_run} !== {sa[i], sb[i], 3'b101}) begin
                    failures++;
                    $display("FAIL %s shift%0d a/b/busy/done/run: got %b%b%b%b%b expected %b%b101",
                             tag, i, a_out, b_out, busy, done, alu_run, sa[i], sb[i]);
                end
            end else if ({a_out, b_out, busy, done, alu_run} !== 5'b00111) begin
                failures++;
                $display("FAIL %s done-cycle a/b/busy/done/run: got %b%b%b%b%b expected 00111",
                         tag, a_out, b_out, busy, done, alu_run);
            end
            tick();
        end
        host_we = 1'b0;
        start = 1'b0;
        if (w) mreg[d] = exp[7:0];
        mflag = exp[8];
        checks++;
        if ({busy, done, a_out, b_out, alu_op} !== {4'b0000, o}) begin
            failures++;
            $display("FAIL %s idle busy/done/a/b/alu_op: got %b%b%b%b %0d expected 0000 %0d",
                     tag, busy, done, a_out, b_out, alu_op, o);
        end
        check_regs(tag);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
        mflag = 1'b0;
        checks++;
        if ({busy, done, alu_run, a_out, b_out, alu_op} !== 8'd0) begin
            failures++;
            $display("FAIL reset outputs: got %b%b%b%b%b %0d expected 00000 0",
                     busy, done, alu_run, a_out, b_out, alu_op);
        end
        check_regs("reset");
        rst = 1'b0;
    endtask

    task automatic test_add();
        host_write(2'd0, 8'hC8);
        host_write(2'd1, 8'h64);
        do_op("add", 3'd0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0, 99, 2'd0, 8'h00);
        checks++;
        if (mreg[2] !== 8'h2C || mflag !== 1'b1) begin
            failures++;
            $display("FAIL add_model: got %02h/%b expected 2c/1", mreg[2], mflag);
        end
    endtask

    task automatic test_sub_alias();
        host_write(2'd0, 8'h05);
        host_write(2'd1, 8'h07);
        do_op("sub_alias", 3'd1, 2'd0, 2'd1, 2'd0, 1'b1, 1'b0, 99, 2'd0, 8'h00);
    endtask

    task automatic test_back_to_back();
        int ndone = 0;
        logic [8:0] s;
        host_write(2'd1, 8'h90);
        host_write(2'd2, 8'h45);
        op = 3'd0; rs1 = 2'd1; rs2 = 2'd2; rd = 2'd1; we = 1'b1; start = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 29) start = 1'b0;
            if (done) ndone++;
            checks++;
            if (done !== (i % 10 == 9)) begin
                failures++;
                $display("FAIL b2b done cycle %0d: got %b expected %b", i, done, (i % 10 == 9));
            end
        end
        for (int k = 0; k < 3; k++) begin
            s = {1'b0, mreg[1]} + {1'b0, mreg[2]};
            mreg[1] = s[7:0];
            mflag = s[8];
        end
        checks++;
        if (ndone != 3) begin
            failures++;
            $display("FAIL b2b done count: got %0d expected 3", ndone);
        end
        check_regs("b2b");
    endtask

    task automatic test_reset_abort();
        int ndone = 0;
        host_write(2'd3, 8'h77);
        host_write(2'd0, 8'h11);
        op = 3'd0; rs1 = 2'd0; rs2 = 2'd0; rd = 2'd3; we = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
        mflag = 1'b0;
        checks++;
        if ({busy, done, alu_run, a_out, b_out, alu_op} !== 8'd0) begin
            failures++;
            $display("FAIL abort outputs: got %b%b%b%b%b %0d expected 00000 0",
                     busy, done, alu_run, a_out, b_out, alu_op);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            failures++;
            $display("FAIL abort stray activity: got %0d cycles expected 0", ndone);
        end
        check_regs("abort");
    endtask

    task automatic test_collision();
        host_write(2'd0, 8'hAA);
        do_op("collide", 3'd6, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0, 8, 2'd2, 8'h55);
        host_write(2'd0, 8'hFF);
        host_write(2'd1, 8'h01);
        do_op("no_we", 3'd0, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0, 99, 2'd0, 8'h00);
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            host_write(2'($urandom_range(0, 3)), 8'($urandom));
            do_op("rand", 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 11)), 2'($urandom_range(0, 3)), 8'($urandom));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'd0; rs1 = 2'd0; rs2 = 2'd0; rd = 2'd0; we = 1'b0;
        host_we = 1'b0; host_addr = 2'd0; host_wdata = 8'h00; host_raddr = 2'd0;
        test_reset();
        test_add();
        test_sub_alias();
        test_back_to_back();
        test_reset_abort();
        test_collision();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
